// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_seq_ctrl
//  Description : Sequencing controller for the LED shift-register datapath.
//                Turns debounced button pulses and board switches into
//                registered load/shift strobes. It runs in manual mode (one
//                shift per press) or auto mode (one shift per prescaled tick,
//                bounded to WIDTH shifts).
//  Revision    : 1.0  initial release
// ============================================================================
module shift_seq_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 26
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   btn_pulse,
    input  logic                         sw_auto,
    input  logic                         sw_dir,
    input  logic [WIDTH-1:0]             sw_data,
    output logic                         sr_load,
    output logic [WIDTH-1:0]             sr_data,
    output logic                         sr_shift,
    output logic                         sr_dir,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic [1:0]                   state,
    output logic                         done
);

    localparam int SC_W = $clog2(WIDTH+1);

    // The counter holds 0 in the first cycle after a go. The strobe is
    // registered one edge after the tick is decoded, so decoding at TICK_DIV-2
    // puts the first shift exactly TICK_DIV cycles after the go pulse. Wrapping
    // at TICK_DIV-1 keeps the spacing between later shifts at TICK_DIV.
    localparam logic [CNT_W-1:0] c_TICK_TERM = CNT_W'(TICK_DIV - 2);
    localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_TICK_ONE  = CNT_W'(1);
    localparam logic [SC_W-1:0]  c_CNT_MAX   = SC_W'(WIDTH);
    localparam logic [SC_W-1:0]  c_CNT_ONE   = SC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10
    } state_t;

    state_t             r_state;
    logic               r_sr_load;
    logic [WIDTH-1:0]   r_sr_data;
    logic               r_sr_shift;
    logic               r_sr_dir;
    logic [SC_W-1:0]    r_shift_cnt;
    logic               r_done;
    logic [CNT_W-1:0]   r_tick_cnt;

    logic               w_tick;
    logic [SC_W-1:0]    w_cnt_inc;

    // Tick decode and the incremented shift count, shared by the FSM branches
    assign w_tick    = (r_tick_cnt == c_TICK_TERM);
    assign w_cnt_inc = r_shift_cnt + c_CNT_ONE;

    // Sequencing FSM: strobes default low each cycle; abort beats go beats tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sr_load   <= 1'b0;
            r_sr_data   <= '0;
            r_sr_shift  <= 1'b0;
            r_sr_dir    <= 1'b0;
            r_shift_cnt <= '0;
            r_done      <= 1'b0;
            r_tick_cnt  <= '0;
        end else begin
            r_sr_load  <= 1'b0;
            r_sr_shift <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Abort has no effect here but still masks a simultaneous go
                    if (!btn_pulse[1] && btn_pulse[0]) begin
                        r_sr_load   <= 1'b1;
                        r_sr_data   <= sw_data;
                        r_shift_cnt <= '0;
                        r_state     <= S_READY;
                    end
                end
                S_READY: begin
                    if (btn_pulse[1]) begin
                        r_state <= S_IDLE;
                    end else if (btn_pulse[0]) begin
                        r_sr_dir <= sw_dir;
                        if (!sw_auto) begin
                            // Manual step: shift is issued even when the count is saturated
                            r_sr_shift <= 1'b1;
                            if (r_shift_cnt != c_CNT_MAX) begin
                                r_shift_cnt <= w_cnt_inc;
                            end
                        end else begin
                            // A finished run restarts from zero; a paused run resumes
                            if (r_shift_cnt == c_CNT_MAX) begin
                                r_shift_cnt <= '0;
                            end
                            r_tick_cnt <= '0;
                            r_state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (btn_pulse[1]) begin
                        r_tick_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else if (btn_pulse[0]) begin
                        r_tick_cnt <= '0;
                        r_state    <= S_READY;
                    end else begin
                        if (r_tick_cnt == c_TICK_LAST) begin
                            r_tick_cnt <= '0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
                        end
                        if (w_tick) begin
                            r_sr_shift  <= 1'b1;
                            r_shift_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_CNT_MAX) begin
                                r_done     <= 1'b1;
                                r_tick_cnt <= '0;
                                r_state    <= S_READY;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sr_load   = r_sr_load;
    assign sr_data   = r_sr_data;
    assign sr_shift  = r_sr_shift;
    assign sr_dir    = r_sr_dir;
    assign shift_cnt = r_shift_cnt;
    assign state     = r_state;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_seq_ctrl
//  Description : Self-checking bench for shift_seq_ctrl (WIDTH=4, TICK_DIV=4)
//                with directed scenarios followed by randomized stimulus,
//                all compared against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_seq_ctrl;

    localparam int c_WIDTH    = 4;
    localparam int c_TICK_DIV = 4;
    localparam int c_CNT_W    = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           btn_pulse;
    logic                 sw_auto;
    logic                 sw_dir;
    logic [c_WIDTH-1:0]   sw_data;
    logic                 sr_load;
    logic [c_WIDTH-1:0]   sr_data;
    logic                 sr_shift;
    logic                 sr_dir;
    logic [2:0]           shift_cnt;
    logic [1:0]           state;
    logic                 done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0=IDLE 1=READY 2=RUN, elapsed = clock edges since go
    int m_state, m_cnt, m_dir, m_data, m_elapsed;
    int e_load, e_shift, e_done;

    shift_seq_ctrl #(
        .WIDTH    (c_WIDTH),
        .TICK_DIV (c_TICK_DIV),
        .CNT_W    (c_CNT_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn_pulse (btn_pulse),
        .sw_auto   (sw_auto),
        .sw_dir    (sw_dir),
        .sw_data   (sw_data),
        .sr_load   (sr_load),
        .sr_data   (sr_data),
        .sr_shift  (sr_shift),
        .sr_dir    (sr_dir),
        .shift_cnt (shift_cnt),
        .state     (state),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour, computed from the rules directly
    task model_step();
        e_load  = 0;
        e_shift = 0;
        e_done  = 0;
        if (reset) begin
            m_state = 0; m_cnt = 0; m_dir = 0; m_data = 0; m_elapsed = 0;
        end else if (m_state == 0) begin
            if (btn_pulse == 2'b01) begin
                e_load = 1; m_data = int'(sw_data); m_cnt = 0; m_state = 1;
            end
        end else if (m_state == 1) begin
            if (btn_pulse[1]) begin
                m_state = 0;
            end else if (btn_pulse[0]) begin
                m_dir = int'(sw_dir);
                if (!sw_auto) begin
                    e_shift = 1;
                    m_cnt   = (m_cnt < c_WIDTH) ? m_cnt + 1 : c_WIDTH;
                end else begin
                    if (m_cnt == c_WIDTH) m_cnt = 0;
                    m_elapsed = 0;
                    m_state   = 2;
                end
            end
        end else begin
            if (btn_pulse[1]) begin
                m_state = 0;
            end else if (btn_pulse[0]) begin
                m_state = 1;
            end else begin
                m_elapsed++;
                // The strobe becomes visible one cycle after this edge, so a
                // shift lands every TICK_DIV cycles counted from the go pulse.
                if ((m_elapsed + 1) % c_TICK_DIV == 0) begin
                    e_shift = 1;
                    m_cnt++;
                    if (m_cnt == c_WIDTH) begin
                        e_done  = 1;
                        m_state = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("sr_load",   int'(sr_load),   e_load);
        check("sr_shift",  int'(sr_shift),  e_shift);
        check("done",      int'(done),      e_done);
        check("state",     int'(state),     m_state);
        check("shift_cnt", int'(shift_cnt), m_cnt);
        check("sr_dir",    int'(sr_dir),    m_dir);
        check("sr_data",   int'(sr_data),   m_data);
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare after it
    task automatic step(input logic rst_v, input logic [1:0] btn_v);
        reset     = rst_v;
        btn_pulse = btn_v;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00);
    endtask

    initial begin
        reset = 1'b1; btn_pulse = 2'b00; sw_auto = 1'b0; sw_dir = 1'b0; sw_data = '0;
        m_state = 0; m_cnt = 0; m_dir = 0; m_data = 0; m_elapsed = 0;

        // Reset state, then idle up to the load
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00);
        check("reset_state", int'(state), 0);
        idle(6);

        // Parallel load
        sw_data = 4'hA;
        step(1'b0, 2'b01);
        check("load_strobe", int'(sr_load), 1);
        check("load_data", int'(sr_data), 'hA);
        check("load_state", int'(state), 1);

        // Manual shifts with saturation at WIDTH
        sw_auto = 1'b0; sw_dir = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 2'b01);
            check("man_shift", int'(sr_shift), 1);
            check("man_cnt", int'(shift_cnt), (i < c_WIDTH) ? i : c_WIDTH);
            idle(1);
        end

        // Full auto run: shifts at T+4..T+16, done with the last one
        sw_auto = 1'b1; sw_dir = 1'b0;
        step(1'b0, 2'b01);
        idle(15);
        check("auto_last_shift", int'(sr_shift), 1);
        check("auto_done", int'(done), 1);
        check("auto_state", int'(state), 1);
        check("auto_cnt", int'(shift_cnt), c_WIDTH);
        idle(2);

        // Pause after two shifts, then resume for the remaining two
        step(1'b0, 2'b01);
        idle(7);
        step(1'b0, 2'b01);
        check("pause_cnt", int'(shift_cnt), 2);
        check("pause_noshift", int'(sr_shift), 0);
        step(1'b0, 2'b01);
        idle(8);
        check("resume_state", int'(state), 1);
        check("resume_cnt", int'(shift_cnt), c_WIDTH);

        // Both buttons on a terminal-count cycle: abort wins, no shift/done
        step(1'b0, 2'b01);
        idle(2);
        step(1'b0, 2'b11);
        check("both_state", int'(state), 0);
        check("both_shift", int'(sr_shift), 0);
        check("both_done", int'(done), 0);
        idle(3);

        // Reset mid-run after one shift
        step(1'b0, 2'b01);
        step(1'b0, 2'b01);
        idle(4);
        step(1'b1, 2'b00);
        check("midrst_state", int'(state), 0);
        check("midrst_shift", int'(sr_shift), 0);
        idle(20);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r_v;
            logic [1:0] b_v;
            if ($urandom_range(19, 0) == 0) sw_auto = ~sw_auto;
            sw_dir  = 1'($urandom);
            sw_data = 4'($urandom);
            r_v     = ($urandom_range(199, 0) == 0);
            b_v[0]  = ($urandom_range(5, 0) == 0);
            b_v[1]  = ($urandom_range(24, 0) == 0);
            step(r_v, b_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
